// File: rtl/regintf_arb_pkg.sv
// regintf_arb_pkg: shared types and constants for the regintf arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, ISSUE, WAIT_RD)
//   REQ_PROG/REQ_HOST: requester identifiers (program driver / host-debug)
//   ADDR_W_DEF/DATA_W_DEF: default regintf address/data widths
package regintf_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  localparam logic REQ_PROG = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regintf_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   valid0/valid1 : request valids
//   last_grant    : requester granted most recently (REQ_PROG/REQ_HOST)
//   grant[1:0]    : one-hot grant, bit N for requester N, zero when idle
module rr_arb2
  import regintf_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      // Contention: whoever was not served last goes first.
      grant = (last_grant == REQ_PROG) ? 2'b10 : 2'b01;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/regintf_arbiter.sv
// regintf_arbiter: shares the single regintf register-file port between the
// program driver (requester 0) and the host/debug path (requester 1), one
// transaction at a time, round-robin.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid/ready         : command handshake per requester
//   reqN_we/addr/wdata       : command (1 = write)
//   reqN_rvalid/rdata        : one-cycle read-return pulse and held data
//   wr_en, rd_en             : regintf strobes (only in ISSUE)
//   addr, write_data         : regintf address/data (held between commands)
//   read_data                : regintf read data, valid RD_LATENCY cycles
//                              after the rd_en cycle
//   busy                     : state is not IDLE
//   dbg_state                : current FSM state
//   req0_lock                : only when REGINTF_ARB_LOCK_EN is defined;
//                              grants requester 0 exclusive access
//
// Handshake: a requester holds valid/we/addr/wdata stable until it sees ready;
// a command transfers on a clock edge where valid && ready. ready is
// combinational and only rises in IDLE for the arbitration winner. Dropping
// valid before ready is legal and issues nothing.
module regintf_arbiter
  import regintf_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
`ifdef REGINTF_ARB_LOCK_EN
  input  logic              req0_lock,
`endif
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  arb_state_t        state_q, state_d;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_grant_q;
  logic [2:0]        cnt_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              arb_valid1;
  logic [1:0]        grant;
  logic              accept;
  logic              last_rd;

`ifdef REGINTF_ARB_LOCK_EN
  logic lock_flag_q;
  logic lock_q;
  assign arb_valid1 = req1_valid && !lock_flag_q;
`else
  assign arb_valid1 = req1_valid;
`endif

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (arb_valid1),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign last_rd    = (state_q == WAIT_RD) && (cnt_q == 3'd1);

  assign wr_en      = (state_q == ISSUE) && we_q;
  assign rd_en      = (state_q == ISSUE) && !we_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : WAIT_RD;
      WAIT_RD: if (last_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= REQ_PROG;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= REQ_HOST;
      cnt_q        <= 3'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      rvalid0_q <= last_rd && (owner_q == REQ_PROG);
      rvalid1_q <= last_rd && (owner_q == REQ_HOST);
      if (accept) begin
        owner_q      <= req1_ready;
        last_grant_q <= req1_ready;
        we_q         <= req1_ready ? req1_we    : req0_we;
        addr_q       <= req1_ready ? req1_addr  : req0_addr;
        wdata_q      <= req1_ready ? req1_wdata : req0_wdata;
      end
      if (state_q == ISSUE && !we_q) begin
        cnt_q <= 3'(RD_LATENCY);
      end else if (state_q == WAIT_RD) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (last_rd && owner_q == REQ_PROG) rdata0_q <= read_data;
      if (last_rd && owner_q == REQ_HOST) rdata1_q <= read_data;
    end
  end

`ifdef REGINTF_ARB_LOCK_EN
  // The flag is released by the first unlocked program command to complete:
  // after its ISSUE cycle for a write, together with rvalid for a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_flag_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      if (accept) lock_q <= req0_ready && req0_lock;
      if (req0_ready && req0_lock) begin
        lock_flag_q <= 1'b1;
      end else if (owner_q == REQ_PROG && !lock_q &&
                   ((state_q == ISSUE && we_q) || last_rd)) begin
        lock_flag_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regintf_arbiter.sv
module tb_regintf_arbiter;

  localparam int AW      = 14;
  localparam int DW      = 16;
  localparam int RD_LAT  = 2;
  localparam int CW      = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, req0_rvalid, req1_rvalid;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          wr_en, rd_en, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data, read_data;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Scoreboard: expected regintf commands and expected read returns.
  logic [CW-1:0] exp_q[$];
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  // Register-file model with RD_LAT-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] d_pipe [RD_LAT];
  logic          v_pipe [RD_LAT];

  regintf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
`ifdef REGINTF_ARB_LOCK_EN
    .req0_lock(req0_lock),
`endif
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
    .read_data(read_data), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en) mem[addr] <= write_data;
    d_pipe[0] <= mem[addr];
    v_pipe[0] <= rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      d_pipe[i] <= d_pipe[i-1];
      v_pipe[i] <= v_pipe[i-1];
    end
  end
  assign read_data = v_pipe[RD_LAT-1] ? d_pipe[RD_LAT-1] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic id, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_q.push_back({we, a, we ? d : 16'h0000});
    if (we) shadow[a] = d;
    else if (id) exp1_q.push_back(shadow[a]);
    else exp0_q.push_back(shadow[a]);
  endtask

  // Monitor: strobes and read returns against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en || rd_en) begin
        chk("strobe_onehot", {31'd0, wr_en & rd_en}, 32'd0);
        if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
        else chk("strobe_cmd", {1'b0, wr_en, addr, wr_en ? write_data : 16'h0000},
                 {1'b0, exp_q.pop_front()});
      end
      if (req0_rvalid) begin
        if (exp0_q.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else chk("rdata0", {16'd0, req0_rdata}, {16'd0, exp0_q.pop_front()});
      end
      if (req1_rvalid) begin
        if (exp1_q.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else chk("rdata1", {16'd0, req1_rdata}, {16'd0, exp1_q.pop_front()});
      end
    end
  end

  // Driver: present one command and wait (bounded) for its accept.
  task automatic issue(input logic id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit got = 0;
    if (id) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
    else    begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        push_cmd(id, we, a, d);
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    req0_lock = 0;
    if (!got) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  int grants [4];
  int acc [3];
  int wr [3];
  int n;
  int nw;
  bit got;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; shadow[i] = '0; end
    for (int i = 0; i < RD_LAT; i++) begin v_pipe[i] = 0; d_pipe[i] = '0; end
    mem[14'h0100] = 16'h1234; shadow[14'h0100] = 16'h1234;

    // Reset state
    #2;
    chk("rst_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    chk("rst_addr_wdata", {2'b0, addr, write_data}, 32'd0);
    chk("rst_rvalid_busy", {29'd0, req0_rvalid, req1_rvalid, busy}, 32'd0);
    chk("rst_rdata", {req0_rdata, req1_rdata}, 32'd0);
    do_reset();

    // req0 write 0x0012 <= 0xBEEF, cycle-exact
    req0_valid = 1; req0_we = 1; req0_addr = 14'h0012; req0_wdata = 16'hBEEF;
    @(negedge clk);
    chk("w_ready0_T", {31'd0, req0_ready}, 32'd1);
    if (req0_ready) push_cmd(0, 1, 14'h0012, 16'hBEEF);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("w_wr_en_T1", {30'd0, wr_en, rd_en}, 32'd2);
    chk("w_addr_data_T1", {2'b0, addr, write_data}, {2'b0, 14'h0012, 16'hBEEF});
    @(negedge clk);
    chk("w_busy_T2", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // req1 read 0x0100, return at T+4
    issue(1, 0, 14'h0100, 16'h0);
    @(negedge clk); chk("r_rd_en_T1", {30'd0, wr_en, rd_en}, 32'd1);
    @(negedge clk); chk("r_no_rvalid_T2", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
    @(negedge clk); chk("r_no_rvalid_T3", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
    @(negedge clk);
    chk("r_rvalid_T4", {30'd0, req0_rvalid, req1_rvalid}, 32'd1);
    chk("r_rdata_T4", {16'd0, req1_rdata}, 32'h1234);
    @(posedge clk); #1;

    // Round-robin with both valid: grants 0,1,0,1 after reset
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 14'h0020; req0_wdata = 16'hA000;
    req1_valid = 1; req1_we = 1; req1_addr = 14'h0030; req1_wdata = 16'hB000;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      chk("rr_no_ready_busy", {31'd0, (req0_ready | req1_ready) & busy}, 32'd0);
      if (req0_ready) begin grants[n] = 0; n++; push_cmd(0, 1, req0_addr, req0_wdata); end
      else if (req1_ready) begin grants[n] = 1; n++; push_cmd(1, 1, req1_addr, req1_wdata); end
      @(posedge clk); #1;
      if (n > 0 && grants[n-1] == 0) begin req0_addr++; req0_wdata++; end
      if (n > 0 && grants[n-1] == 1) begin req1_addr++; req1_wdata++; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", n, 4);
    chk("rr_grants", {grants[0][7:0], grants[1][7:0], grants[2][7:0], grants[3][7:0]},
        32'h00010001);
    repeat (3) @(posedge clk); #1;

    // Back-to-back req0 writes: accept every 2 cycles, wr_en at accept+1
    req0_valid = 1; req0_we = 1; req0_addr = 14'h0200; req0_wdata = 16'h5A00;
    n = 0; nw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en && nw < 3) begin wr[nw] = cyc; nw++; end
      if (req0_ready && n < 3) begin acc[n] = cyc; n++; push_cmd(0, 1, req0_addr, req0_wdata); end
      @(posedge clk); #1;
      if (n == 3) req0_valid = 0;
      req0_addr++; req0_wdata = req0_wdata + 16'h0011;
    end
    chk("b2b_counts", {n[15:0], nw[15:0]}, {16'd3, 16'd3});
    chk("b2b_gap01", acc[1] - acc[0], 2);
    chk("b2b_gap12", acc[2] - acc[1], 2);
    for (int k = 0; k < 3; k++) chk("b2b_wr_lat", wr[k] - acc[k], 1);

    // Reset during WAIT_RD
    issue(1, 0, 14'h0100, 16'h0);
    @(posedge clk); #1;
    chk("mid_state_wait_rd", {30'd0, dbg_state}, 32'd2);
    rst = 1; #1;
    exp_q.delete(); exp0_q.delete(); exp1_q.delete();
    chk("mid_rst_outputs", {26'd0, wr_en, rd_en, req0_rvalid, req1_rvalid, busy, |addr},
        32'd0);
    chk("mid_rst_data", {write_data, req0_rdata | req1_rdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_we = 1; req0_addr = 14'h0040; req0_wdata = 16'h4444;
    req1_valid = 1; req1_we = 1; req1_addr = 14'h0050; req1_wdata = 16'h5555;
    @(negedge clk);
    chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    if (req0_ready) push_cmd(0, 1, 14'h0040, 16'h4444);
    @(posedge clk); #1 req0_valid = 0;
    req1_valid = 0;
    issue(1, 1, 14'h0050, 16'h5555);
    repeat (2) @(posedge clk); #1;

`ifdef REGINTF_ARB_LOCK_EN
    // Locked read from req0 holds off req1 until an unlocked req0 write completes
    req0_lock = 1;
    issue(0, 0, 14'h0012, 16'h0);
    req1_valid = 1; req1_we = 1; req1_addr = 14'h0060; req1_wdata = 16'h6666;
    req0_valid = 1; req0_we = 1; req0_addr = 14'h0070; req0_wdata = 16'h7777;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      chk("lock_req1_blocked", {31'd0, req1_ready}, 32'd0);
      if (req0_ready) begin got = 1; push_cmd(0, 1, 14'h0070, 16'h7777); end
      @(posedge clk); #1;
    end
    req0_valid = 0;
    chk("lock_wr_accepted", {31'd0, got}, 32'd1);
    @(negedge clk); chk("lock_ready1_issue", {31'd0, req1_ready}, 32'd0);
    @(negedge clk); chk("lock_ready1_released", {31'd0, req1_ready}, 32'd1);
    if (req1_ready) push_cmd(1, 1, 14'h0060, 16'h6666);
    @(posedge clk); #1 req1_valid = 0;
`endif

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_cmd_q", exp_q.size(), 0);
    chk("drain_rd_q", exp0_q.size() + exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regintf_arbiter.md
Name: regintf_arbiter

Overview:
- Shares the single regintf register-file port between two requesters, one transaction at a time.
  - Requester 0: program driver (instruction-sequenced reads and writes).
  - Requester 1: host/debug access path.
- Round-robin arbitration.
- Registered command issue to regintf.
- Fixed-latency read-data return to the owning requester.
- Sits between both requesters and the controller's regintf inputs.

Parameters:
- ADDR_W, 14, regintf address width
- DATA_W, 16, regintf data width
- RD_LATENCY, 1, cycles from the rd_en cycle to the cycle read_data is valid; legal range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  register address
- req0_wdata  in  DATA_W  write data
- req0_rvalid  out  1  one-cycle read-return pulse
- req0_rdata  out  DATA_W  read return data
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, req1_rvalid, req1_rdata: same as requester 0
- wr_en  out  1  regintf write strobe
- rd_en  out  1  regintf read strobe
- addr  out  ADDR_W  regintf address
- write_data  out  DATA_W  regintf write data
- read_data  in  DATA_W  regintf read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state=IDLE, last_grant=1, so requester 0 wins first.
  - wr_en, rd_en, addr, write_data = 0.
  - rvalid = 0 and rdata = 0 for both requesters; busy = 0.
- Handshake:
  - Requester holds valid/we/addr/wdata stable until ready.
  - Withdrawing valid before ready is legal; nothing is issued.
  - reqN_ready is combinational: high only in IDLE, when reqN_valid=1 and reqN wins arbitration.
- Arbitration in IDLE:
  - Single valid wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates on accept.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE, accept in cycle T:
  - Latch owner, we, addr, wdata.
  - Next state ISSUE.
- ISSUE, cycle T+1:
  - Exactly one of wr_en/rd_en is high for this one cycle.
  - addr and write_data driven from registers.
  - Write: next state IDLE. A new accept is possible at T+2.
  - Read: load counter = RD_LATENCY; next state WAIT_RD.
- WAIT_RD, cycles T+2 .. T+1+RD_LATENCY:
  - Counter decrements.
  - On the last cycle, read_data is captured into the owner's rdata.
  - Next state IDLE.
- Read return, cycle T+2+RD_LATENCY:
  - Owner's rvalid=1 for one cycle.
  - A new accept may occur in the same cycle.
- rdata holds its value until that requester's next read completes. The non-owner's rvalid and rdata are untouched.
- addr and write_data hold their last value outside ISSUE; strobes are 0.
- Only one transaction is outstanding at a time; no pipelining.
- Reset mid-transaction aborts it: no strobe, no rvalid afterwards.
- Both requesters targeting the same address are serialized in grant order; no hazard logic.

Optional Feature:
- Macro REGINTF_ARB_LOCK_EN.
- When defined:
  - Adds input req0_lock (1 bit), sampled with the command at accept.
  - An accepted req0 command with lock=1 sets a lock flag.
  - While the flag is set, req1 is never granted and req0 has exclusive access.
  - The flag clears when a req0 command with lock=0 completes: end of ISSUE for a write, rvalid cycle for a read.
  - The flag resets to 0.
  - Purpose: atomic read-modify-write and wait-on-completion sequences from the program driver.
- When undefined: the port does not exist and arbitration is pure round-robin.

Decomposition:
- Package regintf_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT_RD).
  - Requester-ID constants (REQ_PROG=0, REQ_HOST=1).
  - Default ADDR_W/DATA_W localparams.
- One sub-module: rr_arb2, a combinational 2-way round-robin pick from the two valids and last_grant, producing a one-hot grant.
- The FSM, counter and datapath stay in the top module.

Test Plan:
- Reset release, then req0 write addr=0x0012, wdata=0xBEEF:
  - ready0 at T.
  - wr_en=1 with addr=0x0012, write_data=0xBEEF at T+1.
  - busy low at T+2.
- req1 read addr=0x0100, RD_LATENCY=2, regfile drives 0x1234 at T+3:
  - rd_en at T+1.
  - req1_rvalid=1 with req1_rdata=0x1234 at T+4.
  - req0_rvalid stays 0.
- Both valid continuously for four transactions:
  - Grants alternate 0,1,0,1.
  - No ready asserts outside IDLE.
- Back-to-back writes from req0 only: accepts every 2 cycles, wr_en pulses at T+1, T+3, T+5.
- Assert rst during WAIT_RD:
  - All outputs 0 immediately.
  - No rvalid afterwards.
  - First post-reset grant goes to req0.
- With REGINTF_ARB_LOCK_EN:
  - req0 locked read, then req1 valid held: req1 never ready.
  - req0 unlocked write completes: req1 ready in the next IDLE cycle.
